// File: rtl/bw_rf_16x81_fifo_ctl_if.sv
// Handshake and register-file control bundle for the 16x81 FIFO controller.
// The master drives push/pop/flush; the controller (slave) drives the rest.
interface bw_rf_16x81_fifo_ctl_if;
  logic       push;
  logic       pop;
  logic       flush;
  logic       push_rdy;
  logic       pop_rdy;
  logic       rd_vld;
  logic [4:0] count;
  logic       afull;
  logic       ovf_err;
  logic       udf_err;
  logic       init_done;
  logic       rf_csn_wr;
  logic       rf_csn_rd;
  logic [3:0] rf_wr_a;
  logic [3:0] rf_rd_a;
  logic       rf_di_zero;
  logic       rf_hold;
  logic       rf_testmux_sel;

  modport master (
    output push, pop, flush,
    input  push_rdy, pop_rdy, rd_vld, count, afull,
    input  ovf_err, udf_err, init_done,
    input  rf_csn_wr, rf_csn_rd, rf_wr_a, rf_rd_a,
    input  rf_di_zero, rf_hold, rf_testmux_sel
  );

  modport slave (
    input  push, pop, flush,
    output push_rdy, pop_rdy, rd_vld, count, afull,
    output ovf_err, udf_err, init_done,
    output rf_csn_wr, rf_csn_rd, rf_wr_a, rf_rd_a,
    output rf_di_zero, rf_hold, rf_testmux_sel
  );
endinterface

// File: rtl/bw_rf_16x81_fifo_ctl.sv
// FIFO controller for a 16x81 register file: zero-fill scrub after reset,
// then pointer/count management with one-cycle read latency.
module bw_rf_16x81_fifo_ctl #(
  parameter int AFULL_THR = 12,
  parameter bit SCRUB_EN  = 1'b1
) (
  input logic                     rclk,
  input logic                     rst,
  bw_rf_16x81_fifo_ctl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [31:0] THR = AFULL_THR;

  state_e     state_q, state_d;
  logic [3:0] scrub_q, scrub_d;
  logic [3:0] wptr_q, wptr_d;
  logic [3:0] rptr_q, rptr_d;
  logic [4:0] count_q, count_d;
  logic       rd_vld_q, rd_vld_d;
  logic       ovf_q, ovf_d;
  logic       udf_q, udf_d;

  logic run;
  logic full;
  logic empty;
  logic push_rdy;
  logic pop_rdy;
  logic push_ok;
  logic pop_ok;

  assign run      = (state_q == RUN);
  assign full     = (count_q == 5'd16);
  assign empty    = (count_q == 5'd0);
  assign push_rdy = run & ~full & ~bus.flush;
  assign pop_rdy  = run & ~empty & ~bus.flush;
  assign push_ok  = bus.push & push_rdy;
  assign pop_ok   = bus.pop & pop_rdy;

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      scrub_q <= 4'd0;
    end else begin
      state_q <= state_d;
      scrub_q <= scrub_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scrub_d = scrub_q;
    unique case (state_q)
      IDLE: begin
        scrub_d = 4'd0;
        state_d = SCRUB_EN ? SCRUB : RUN;
      end
      SCRUB: begin
        scrub_d = scrub_q + 4'd1;
        if (scrub_q == 4'hF) state_d = RUN;
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Refusing push when full keeps read and write addresses disjoint.
  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rd_vld_d = pop_ok;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (run && bus.flush) begin
      wptr_d  = 4'd0;
      rptr_d  = 4'd0;
      count_d = 5'd0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 4'd1;
      if (pop_ok)  rptr_d = rptr_q + 4'd1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 5'd1;
        2'b01:   count_d = count_q - 5'd1;
        default: count_d = count_q;
      endcase
      if (run && bus.push && !push_rdy) ovf_d = 1'b1;
      if (run && bus.pop && !pop_rdy)   udf_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      wptr_q   <= 4'd0;
      rptr_q   <= 4'd0;
      count_q  <= 5'd0;
      rd_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rd_vld_q <= rd_vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // RF strobes are combinational so they meet di at the same edge.
  always_comb begin
    bus.rf_csn_wr  = 1'b1;
    bus.rf_wr_a    = wptr_q;
    bus.rf_di_zero = 1'b0;
    bus.rf_csn_rd  = 1'b1;
    bus.rf_rd_a    = rptr_q;
    unique case (1'b1)
      (state_q == SCRUB): begin
        bus.rf_csn_wr  = 1'b0;
        bus.rf_wr_a    = scrub_q;
        bus.rf_di_zero = 1'b1;
      end
      run: begin
        bus.rf_csn_wr = ~push_ok;
        bus.rf_csn_rd = ~pop_ok;
      end
      default: begin
        bus.rf_csn_wr = 1'b1;
      end
    endcase
  end

  assign bus.push_rdy       = push_rdy;
  assign bus.pop_rdy        = pop_rdy;
  assign bus.rd_vld         = rd_vld_q;
  assign bus.count          = count_q;
  assign bus.afull          = ({27'd0, count_q} >= THR);
  assign bus.ovf_err        = ovf_q;
  assign bus.udf_err        = udf_q;
  assign bus.init_done      = run;
  assign bus.rf_hold        = 1'b0;
  assign bus.rf_testmux_sel = 1'b0;

endmodule

// File: tb/tb_bw_rf_16x81_fifo_ctl.sv
// Bench for bw_rf_16x81_fifo_ctl: directed and random traffic against a
// queue-based reference, with a small RF model wired to the strobes.
module tb_bw_rf_16x81_fifo_ctl;

  logic        rclk = 1'b0;
  logic        rst  = 1'b0;
  logic [80:0] di;
  logic [80:0] rf_do;
  logic [80:0] mem [16];

  int checks = 0;
  int errors = 0;

  int          phase;
  int          sidx;
  logic [80:0] q[$];
  int          npush;
  int          npop;
  bit          m_ovf;
  bit          m_udf;
  bit          m_rdv;
  logic [80:0] m_do;

  bw_rf_16x81_fifo_ctl_if bus();

  bw_rf_16x81_fifo_ctl #(
    .AFULL_THR(12),
    .SCRUB_EN(1'b1)
  ) dut (
    .rclk(rclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 rclk = ~rclk;

  always_ff @(posedge rclk) begin
    if (!bus.rf_csn_wr) mem[bus.rf_wr_a] <= bus.rf_di_zero ? 81'd0 : di;
    if (!bus.rf_csn_rd) rf_do <= mem[bus.rf_rd_a];
  end

  task automatic chk(string tag, logic [80:0] obs, logic [80:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [80:0] rnd81();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[80:0];
  endfunction

  task automatic model_clear();
    phase = 0;
    sidx  = 0;
    q.delete();
    npush = 0;
    npop  = 0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rdv = 1'b0;
  endtask

  task automatic step(bit p, bit o, bit f, logic [80:0] d);
    bit run, prdy, ordy, pacc, oacc;
    @(negedge rclk);
    bus.push  = p;
    bus.pop   = o;
    bus.flush = f;
    di        = d;
    #1;
    run  = (phase == 2);
    prdy = run && (q.size() != 16) && !f;
    ordy = run && (q.size() != 0) && !f;
    pacc = p && prdy;
    oacc = o && ordy;
    chk("push_rdy", 81'(bus.push_rdy), 81'(prdy));
    chk("pop_rdy", 81'(bus.pop_rdy), 81'(ordy));
    chk("count", 81'(bus.count), 81'(q.size()));
    chk("afull", 81'(bus.afull), 81'(q.size() >= 12));
    chk("ovf_err", 81'(bus.ovf_err), 81'(m_ovf));
    chk("udf_err", 81'(bus.udf_err), 81'(m_udf));
    chk("rd_vld", 81'(bus.rd_vld), 81'(m_rdv));
    if (m_rdv) chk("rd_data", rf_do, m_do);
    chk("init_done", 81'(bus.init_done), 81'(run));
    chk("rf_hold", 81'(bus.rf_hold), 81'(0));
    chk("testmux", 81'(bus.rf_testmux_sel), 81'(0));
    chk("di_zero", 81'(bus.rf_di_zero), 81'(phase == 1));
    if (phase == 1) begin
      chk("scrub_csn_wr", 81'(bus.rf_csn_wr), 81'(0));
      chk("scrub_wr_a", 81'(bus.rf_wr_a), 81'(sidx));
    end else if (run) begin
      chk("csn_wr", 81'(bus.rf_csn_wr), 81'(!pacc));
      chk("wr_a", 81'(bus.rf_wr_a), 81'(npush % 16));
      chk("rd_a", 81'(bus.rf_rd_a), 81'(npop % 16));
    end else begin
      chk("idle_csn_wr", 81'(bus.rf_csn_wr), 81'(1));
    end
    chk("csn_rd", 81'(bus.rf_csn_rd), 81'(run ? !oacc : 1'b1));
    @(posedge rclk);
    if (phase == 0) begin
      phase = 1;
      sidx  = 0;
      m_rdv = 1'b0;
    end else if (phase == 1) begin
      if (sidx == 15) phase = 2;
      else sidx++;
      m_rdv = 1'b0;
    end else if (f) begin
      q.delete();
      npush = 0;
      npop  = 0;
      m_rdv = 1'b0;
    end else begin
      if (p && !prdy) m_ovf = 1'b1;
      if (o && !ordy) m_udf = 1'b1;
      m_rdv = oacc;
      if (oacc) begin
        m_do = q.pop_front();
        npop++;
      end
      if (pacc) begin
        q.push_back(d);
        npush++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge rclk);
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
    #2;
    if (phase == 1) chk("pre_rst_wr_a", 81'(bus.rf_wr_a), 81'(sidx));
    rst = 1'b1;
    #1;
    chk("rst_push_rdy", 81'(bus.push_rdy), 81'(0));
    chk("rst_pop_rdy", 81'(bus.pop_rdy), 81'(0));
    chk("rst_csn_wr", 81'(bus.rf_csn_wr), 81'(1));
    chk("rst_csn_rd", 81'(bus.rf_csn_rd), 81'(1));
    chk("rst_di_zero", 81'(bus.rf_di_zero), 81'(0));
    chk("rst_count", 81'(bus.count), 81'(0));
    chk("rst_afull", 81'(bus.afull), 81'(0));
    chk("rst_ovf", 81'(bus.ovf_err), 81'(0));
    chk("rst_udf", 81'(bus.udf_err), 81'(0));
    chk("rst_init_done", 81'(bus.init_done), 81'(0));
    chk("rst_rd_vld", 81'(bus.rd_vld), 81'(0));
    model_clear();
    @(posedge rclk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
    di        = '0;
    model_clear();

    do_reset();
    for (int i = 0; i < 18; i++) step(0, 0, 0, '0);

    for (int i = 0; i < 16; i++) step(1, 0, 0, 81'(i));
    step(1, 0, 0, 81'd99);
    step(1, 1, 0, 81'd77);
    step(0, 0, 0, '0);
    step(0, 0, 1, '0);

    step(1, 1, 0, rnd81());
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 1, '0);

    for (int i = 0; i < 10; i++) step(1, 0, 0, rnd81());
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, rnd81());
    for (int i = 0; i < 10; i++) step(0, 1, 0, '0);
    step(0, 0, 0, '0);

    for (int i = 0; i < 200; i++)
      step(($urandom % 3) != 0, ($urandom % 3) == 0,
           ($urandom % 40) == 0, rnd81());
    for (int i = 0; i < 200; i++)
      step(($urandom % 3) == 0, ($urandom % 3) != 0,
           ($urandom % 40) == 0, rnd81());

    do_reset();
    guard = 0;
    while (!(phase == 1 && sidx == 7) && guard < 40) begin
      step(0, 0, 0, '0);
      guard++;
    end
    chk("reach_scrub7", 81'(guard < 40), 81'(1));
    do_reset();
    for (int i = 0; i < 18; i++) step(0, 0, 0, '0);
    for (int i = 0; i < 60; i++)
      step($urandom % 2, $urandom % 2, ($urandom % 30) == 0, rnd81());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
